// File: rtl/branch_predict_resolve.sv
// rtl/branch_predict_resolve.sv - BHT branch predictor with EX resolution, redirect and flush (optional stats: BRANCH_STATS_EN)
module branch_predict_resolve #(
  parameter int PC_WIDTH    = 32,
  parameter int BHT_DEPTH   = 64,
  parameter int STATS_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    if_pc,
  output logic                   pred_taken,
  input  logic                   ex_valid,
  input  logic                   ex_stall,
  input  logic [PC_WIDTH-1:0]    ex_pc,
  input  logic                   ex_is_jump,
  input  logic                   ex_branch_eq,
  input  logic                   ex_branch_ne,
  input  logic                   ex_zero,
  input  logic                   ex_pred_taken,
  output logic                   redirect_valid,
  output logic                   redirect_taken,
`ifdef BRANCH_STATS_EN
  output logic [STATS_WIDTH-1:0] branch_count,
  output logic [STATS_WIDTH-1:0] mispredict_count,
`endif
  output logic                   flush
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  // Two-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  logic [1:0] bht [BHT_DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             is_ctrl;
  logic             active;
  logic             actual;
  logic             counted;
  logic             mispredict;
  logic             unused_pc_bits;

  // Word-aligned PCs; low two bits and bits above the index alias freely
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc, ex_pc};

  // Lookup reads the table before any same-cycle update lands
  assign pred_taken = bht[if_idx][1];

  assign is_ctrl = ex_is_jump | ex_branch_eq | ex_branch_ne;
  assign active  = ex_valid & ~ex_stall & is_ctrl;

  // Decode priority when several kinds are flagged: jump, then beq, then bne
  always_comb begin
    actual = 1'b0;
    if (ex_is_jump)
      actual = 1'b1;
    else if (ex_branch_eq)
      actual = ex_zero;
    else if (ex_branch_ne)
      actual = ~ex_zero;
  end

  // The instruction behind a redirect is squashed upstream, so it neither trains nor redirects
  assign counted    = active & ~redirect_valid;
  assign mispredict = counted & (actual != ex_pred_taken);

  // BHT training: jumps pin to strong-taken, conditionals step toward the outcome
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= 2'b01;
    end else if (counted) begin
      if (ex_is_jump)
        bht[ex_idx] <= 2'b11;
      else if (actual && bht[ex_idx] != 2'b11)
        bht[ex_idx] <= bht[ex_idx] + 2'b01;
      else if (!actual && bht[ex_idx] != 2'b00)
        bht[ex_idx] <= bht[ex_idx] - 2'b01;
    end
  end

  // One-cycle registered redirect/flush pulse; a stall lets the pulse end but keeps the direction
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_taken <= 1'b0;
      flush          <= 1'b0;
    end else if (ex_stall) begin
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
    end else begin
      redirect_valid <= mispredict;
      flush          <= mispredict;
      redirect_taken <= mispredict & actual;
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating resolution and misprediction counters
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (counted && branch_count != '1)
        branch_count <= branch_count + 1'b1;
      if (mispredict && mispredict_count != '1)
        mispredict_count <= mispredict_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb/tb_branch_predict_resolve.sv - directed self-checking bench for branch_predict_resolve
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid, ex_stall;
  logic [31:0] ex_pc;
  logic        ex_is_jump, ex_branch_eq, ex_branch_ne, ex_zero, ex_pred_taken;
  logic        redirect_valid, redirect_taken, flush;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef BRANCH_STATS_EN
  logic [15:0] branch_count, mispredict_count;
  logic        ex_valid2;
  logic        pred_taken2, redirect_valid2, redirect_taken2, flush2;
  logic [1:0]  branch_count2, mispredict_count2;
`endif

  branch_predict_resolve #(.PC_WIDTH(32), .BHT_DEPTH(64), .STATS_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc),
    .ex_is_jump(ex_is_jump), .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne),
    .ex_zero(ex_zero), .ex_pred_taken(ex_pred_taken),
    .redirect_valid(redirect_valid), .redirect_taken(redirect_taken),
`ifdef BRANCH_STATS_EN
    .branch_count(branch_count), .mispredict_count(mispredict_count),
`endif
    .flush(flush)
  );

`ifdef BRANCH_STATS_EN
  branch_predict_resolve #(.PC_WIDTH(32), .BHT_DEPTH(64), .STATS_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken2),
    .ex_valid(ex_valid2), .ex_stall(ex_stall), .ex_pc(ex_pc),
    .ex_is_jump(ex_is_jump), .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne),
    .ex_zero(ex_zero), .ex_pred_taken(ex_pred_taken),
    .redirect_valid(redirect_valid2), .redirect_taken(redirect_taken2),
    .branch_count(branch_count2), .mispredict_count(mispredict_count2),
    .flush(flush2)
  );
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic j, input logic eq, input logic ne,
                        input logic z, input logic p);
    ex_valid = 1'b1; ex_pc = pc; ex_is_jump = j; ex_branch_eq = eq;
    ex_branch_ne = ne; ex_zero = z; ex_pred_taken = p;
  endtask

  task automatic clear_ex;
    ex_valid = 1'b0; ex_is_jump = 1'b0; ex_branch_eq = 1'b0; ex_branch_ne = 1'b0;
    ex_zero = 1'b0; ex_pred_taken = 1'b0; ex_stall = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; if_pc = 32'h40; clear_ex();
`ifdef BRANCH_STATS_EN
    ex_valid2 = 1'b0;
`endif
    tick();
    reset = 1'b0;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_pred: got %b expected 0", pred_taken);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle cycle %0d: valid=%b flush=%b expected 0,0", i, redirect_valid, flush);
      end
      tick();
    end
  endtask

  task automatic test_beq_taken;
    if_pc = 32'h40;
    set_ex(32'h40, 0, 1, 0, 1, 0);
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL beq_pre_update_pred: got %b expected 0", pred_taken);
    end
    tick();
    clear_ex();
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_taken !== 1'b1 || flush !== 1'b1) begin
      n_fail++; $display("FAIL beq_redirect: valid=%b taken=%b flush=%b expected 1,1,1", redirect_valid, redirect_taken, flush);
    end
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL beq_bht_10: got %b expected 1", pred_taken);
    end
    tick();
    n_checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL beq_pulse_end: valid=%b flush=%b expected 0,0", redirect_valid, flush);
    end
  endtask

  task automatic test_bne_saturate;
    if_pc = 32'h44;
    for (int i = 0; i < 2; i++) begin
      set_ex(32'h44, 0, 0, 1, 1, 0);
      tick();
      n_checks++;
      if (redirect_valid !== 1'b0) begin
        n_fail++; $display("FAIL bne_no_redirect %0d: got %b expected 0", i, redirect_valid);
      end
    end
    // Counter must be 00: one taken outcome only reaches 01
    set_ex(32'h44, 0, 1, 0, 1, 0);
    tick();
    clear_ex();
    n_checks++;
    if (pred_taken !== 1'b0 || redirect_valid !== 1'b1) begin
      n_fail++; $display("FAIL bne_saturated_00: pred=%b valid=%b expected 0,1", pred_taken, redirect_valid);
    end
    tick();
  endtask

  task automatic test_jump_squash;
    set_ex(32'h48, 1, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_taken !== 1'b1) begin
      n_fail++; $display("FAIL jump_redirect: valid=%b taken=%b expected 1,1", redirect_valid, redirect_taken);
    end
    // Would-be mispredict in the redirect cycle is ignored
    set_ex(32'h4C, 0, 1, 0, 1, 0);
    tick();
    clear_ex();
    if_pc = 32'h4C;
    n_checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL squash_ignored: valid=%b flush=%b pred=%b expected 0,0,0", redirect_valid, flush, pred_taken);
    end
    // Jump entry is 11: one not-taken still predicts taken, redirect toward pc+4
    if_pc = 32'h48;
    set_ex(32'h48, 0, 0, 1, 1, 1);
    tick();
    clear_ex();
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_taken !== 1'b0 || pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL jump_strong_11: valid=%b taken=%b pred=%b expected 1,0,1", redirect_valid, redirect_taken, pred_taken);
    end
    tick();
  endtask

  task automatic test_stall;
    if_pc = 32'h50;
    set_ex(32'h50, 0, 1, 0, 1, 0);
    ex_stall = 1'b1;
    tick();
    clear_ex();
    n_checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold: valid=%b flush=%b pred=%b expected 0,0,0", redirect_valid, flush, pred_taken);
    end
  endtask

  task automatic test_priority_alias;
    // beq and bne both set, zero=0: beq wins so outcome is not-taken, no mispredict
    if_pc = 32'h54;
    set_ex(32'h54, 0, 1, 1, 0, 0);
    tick();
    clear_ex();
    n_checks++;
    if (redirect_valid !== 1'b0) begin
      n_fail++; $display("FAIL priority_beq: valid=%b expected 0", redirect_valid);
    end
    // 0x143 aliases index 16 (trained to 10 earlier)
    if_pc = 32'h143;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL alias_idx16: got %b expected 1", pred_taken);
    end
  endtask

  task automatic test_reset_mid_redirect;
    set_ex(32'h60, 0, 1, 0, 1, 0);
    tick();
    clear_ex();
    reset = 1'b1;
    n_checks++;
    if (redirect_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_redirect: got %b expected 1", redirect_valid);
    end
    tick();
    reset = 1'b0;
    if_pc = 32'h40;
    #1;
    n_checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_cancel: valid=%b flush=%b pred=%b expected 0,0,0", redirect_valid, flush, pred_taken);
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats;
    for (int i = 0; i < 10; i++) begin
      set_ex(32'h80, 0, 1, 0, 0, (i < 3) ? 1'b1 : 1'b0);
      tick();
      clear_ex();
      tick();
    end
    n_checks++;
    if (branch_count !== 16'd10 || mispredict_count !== 16'd3) begin
      n_fail++; $display("FAIL stats_counts: branch=%0d mispredict=%0d expected 10,3", branch_count, mispredict_count);
    end
    for (int i = 0; i < 5; i++) begin
      ex_valid2 = 1'b1; ex_pc = 32'h84; ex_branch_eq = 1'b1; ex_zero = 1'b0; ex_pred_taken = 1'b0;
      tick();
    end
    ex_valid2 = 1'b0;
    clear_ex();
    n_checks++;
    if (branch_count2 !== 2'd3 || mispredict_count2 !== 2'd0) begin
      n_fail++; $display("FAIL stats_saturate: branch=%0d mispredict=%0d expected 3,0", branch_count2, mispredict_count2);
    end
  endtask
`endif

  initial begin
    ex_pc = 32'h0;
    test_reset();
    test_beq_taken();
    test_bne_saturate();
    test_jump_squash();
    test_stall();
    test_priority_alias();
    test_reset_mid_redirect();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
